mult_share_arbiter: RTL
=======================

# mult_share_arbiter

Round-robin scheduler that shares one pipelined signed 32x32 Wallace-tree multiplier between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier operand bus. It tracks each issued operation through a tag pipeline matched to the multiplier latency, then returns each 64-bit product to its owner through a per-requester result register with valid/ready.

## Interface
- NREQ, 4: number of requesters, 2..8
- MUL_LATENCY, 1: edges from multiplier operand sampling to the matching `mul_p`, 1..4
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i holds an operand pair
- req_ready  out  NREQ  one-hot grant; a handshake occurs when valid&ready at a rising edge
- req_a  in  NREQ*32  signed operand A, slice i = [32i+31:32i]
- req_b  in  NREQ*32  signed operand B, same slicing
- mul_a  out  32  operand A to the shared multiplier
- mul_b  out  32  operand B to the shared multiplier
- mul_p  in  64  product from the multiplier, MUL_LATENCY cycles after sampling
- rsp_valid  out  NREQ  result register i is full
- rsp_ready  in  NREQ  requester i consumes its result
- rsp_p  out  NREQ*64  signed product, slice i = [64i+63:64i]

## Operation
- Eligible(i) = req_valid[i] & ~busy[i].
- busy[i] is set on the request handshake. It clears on the rsp_valid[i]&rsp_ready[i] handshake.
- Each requester has at most one operation outstanding, counting both in-flight and unconsumed results.
- Arbitration is combinational round-robin over eligible requesters. The search starts at ptr and wraps NREQ-1→0.
- At most one req_ready bit is high per cycle. req_ready never asserts for an ineligible requester.
- On a grant to i, ptr becomes (i+1) mod NREQ. ptr is unchanged in cycles with no grant.
- mul_a/mul_b carry the granted requester's operands in the same cycle. They are 0 when there is no grant.
- Tag pipeline: MUL_LATENCY stages of {valid, idx}. Stage 0 loads {grant_any, granted idx}.
- When the last stage is valid, mul_p is written into rsp_p slice idx and rsp_valid[idx] is set.
- rsp_valid[i] clears on its handshake. rsp_p holds its value until the slice is overwritten.
- Products pass through unmodified: full signed 64-bit, no truncation or saturation.

## Timing
- Reset values: req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_p=0, busy=0, ptr=0, all tag stages invalid.
- Reset is asynchronous and takes effect immediately.
- Reset mid-operation discards in-flight tags and pending results. Products arriving after deassertion are ignored.
- Latency: request handshake at edge E → rsp_valid rises at edge E+MUL_LATENCY.
- Throughput: one grant per cycle across requesters. Per requester, the next grant comes no earlier than the cycle after its rsp handshake.
- Response handshake and re-request for the same requester in the same cycle: busy clears at that edge, and the new grant comes no earlier than the following cycle. There is no bypass.
- Requesters returning results in the same cycle each write their own slice, so there is no conflict.
- req_valid may drop without a handshake. The arbiter re-evaluates every cycle and the grant is not sticky.
- Backpressure on rsp_ready never stalls other requesters.

## Structure
- Package `mult_arb_pkg`:
  - OP_W=32 and PROD_W=64
  - tag struct {valid, idx[$clog2(NREQ)-1:0]}
  - MAX_NREQ=8
- Sub-module `rr_picker`: elig[NREQ] and ptr in; one-hot grant and encoded idx out. Purely combinational.
- Top-level contents: busy, ptr, the tag shift register, result registers, and operand muxing.

## Test plan
- Single requester, MUL_LATENCY=1: req0 sends a=1345, b=2345 → rsp_valid[0] one edge after the handshake, rsp_p[0]=3154025. busy blocks a second grant until rsp_ready[0].
- All four requesters valid continuously with rsp_ready=1 → grants 0,1,2,3,0… The operand pairs used are:
  - −15313131 × −2031232132
  - 15313131 × −2031232132
  - 0 × x
  - 1 × 2031232132
  - Each rsp_p must match the signed 64-bit reference product.
- Corner products: a=32'h80000000, b=32'h7FFFFFFF → 64'hC000000080000000; a=b=32'h80000000 → 64'h4000000000000000.
- rsp_ready[2] held 0 for 10 cycles with all requesters valid → requester 2 gets no further grant, others continue round-robin, rsp_p[2] stays stable.
- MUL_LATENCY=3, with reset pulled low while two operations are in flight → all outputs 0 immediately, and no rsp_valid rises after reset is released until new handshakes occur.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared widths, tag type and pointer helper for the multiplier-sharing arbiter.
// Tag indices are sized for the largest supported requester count.
package mult_arb_pkg;

  localparam int OP_W     = 32;
  localparam int PROD_W   = 64;
  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = $clog2(MAX_NREQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Round-robin successor of idx, wrapping at nreq-1.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int               nreq);
    logic [IDX_W-1:0] nxt;
    nxt = (int'(idx) == (nreq - 1)) ? '0 : idx + IDX_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester handshakes, result return and the shared multiplier operand/product bus.
// The arbiter is the slave; requesters plus the multiplier sit on the master side.
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*OP_W-1:0]   req_a;
  logic [NREQ*OP_W-1:0]   req_b;
  logic [OP_W-1:0]        mul_a;
  logic [OP_W-1:0]        mul_b;
  logic [PROD_W-1:0]      mul_p;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ*PROD_W-1:0] rsp_p;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_p
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_p
  );

endinterface

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping to the lowest eligible index when nothing at or above ptr is eligible.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic             hi_sel_s;
  logic             hi_any_s;
  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;

  // Descending scan so the lowest qualifying index wins in each half.
  always_comb begin
    hi_sel_s = 1'b0;
    hi_any_s = 1'b0;
    hi_idx_s = '0;
    lo_idx_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      hi_sel_s = elig_i[i] && (IDX_W'(i) >= ptr_i);
      hi_idx_s = hi_sel_s ? IDX_W'(i) : hi_idx_s;
      hi_any_s = hi_any_s | hi_sel_s;
      lo_idx_s = elig_i[i] ? IDX_W'(i) : lo_idx_s;
    end
  end

  // Encoded winner and its one-hot grant.
  always_comb begin
    any_o   = |elig_i;
    idx_o   = hi_any_s ? hi_idx_s : lo_idx_s;
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = any_o && (idx_o == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined signed 32x32 multiplier among NREQ requesters: round-robin
// issue, a tag pipeline matched to the multiplier latency, per-requester result registers.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_share_arbiter_if.slave  bus
);

  logic [NREQ-1:0]        busy_q;
  logic [NREQ-1:0]        busy_d;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       ptr_d;
  logic [NREQ-1:0]        rsp_valid_q;
  logic [NREQ-1:0]        rsp_valid_d;
  logic [NREQ*PROD_W-1:0] rsp_p_q;
  logic [NREQ*PROD_W-1:0] rsp_p_d;
  tag_t                   tag_q [MUL_LATENCY];
  tag_t                   tag_d [MUL_LATENCY];

  logic [NREQ-1:0]        elig_s;
  logic [NREQ-1:0]        grant_s;
  logic [IDX_W-1:0]       grant_idx_s;
  logic                   grant_any_s;
  logic [OP_W-1:0]        mul_a_s;
  logic [OP_W-1:0]        mul_b_s;
  tag_t                   last_s;
  logic                   wr_s;

  // Gating with reset keeps req_ready and the operand bus at zero while reset is held.
  assign elig_s = bus.req_valid & ~busy_q & {NREQ{reset}};

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .elig_i  (elig_s),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .idx_o   (grant_idx_s),
    .any_o   (grant_any_s)
  );

  // One-hot AND-OR operand mux; the bus reads zero when nothing is granted.
  always_comb begin
    mul_a_s = '0;
    mul_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      mul_a_s = mul_a_s | ({OP_W{grant_s[i]}} & bus.req_a[i*OP_W +: OP_W]);
      mul_b_s = mul_b_s | ({OP_W{grant_s[i]}} & bus.req_b[i*OP_W +: OP_W]);
    end
  end

  // Pointer, busy and tag pipeline next state.
  always_comb begin
    ptr_d  = grant_any_s ? rr_next(grant_idx_s, NREQ) : ptr_q;
    busy_d = (busy_q | grant_s) & ~(rsp_valid_q & bus.rsp_ready);
    tag_d[0].valid = grant_any_s;
    tag_d[0].idx   = grant_idx_s;
    for (int s = 1; s < MUL_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // A valid last-stage tag captures mul_p into its owner's slice; setting wins over consuming.
  always_comb begin
    last_s      = tag_q[MUL_LATENCY-1];
    wr_s        = 1'b0;
    rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
    rsp_p_d     = rsp_p_q;
    for (int i = 0; i < NREQ; i++) begin
      wr_s           = last_s.valid && (last_s.idx == IDX_W'(i));
      rsp_valid_d[i] = rsp_valid_d[i] | wr_s;
      rsp_p_d[i*PROD_W +: PROD_W] = wr_s ? bus.mul_p : rsp_p_q[i*PROD_W +: PROD_W];
    end
  end

  // State registers; reset discards in-flight tags and pending results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.mul_a     = mul_a_s;
  assign bus.mul_b     = mul_b_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_p     = rsp_p_q;

endmodule
